// File: rtl/piso_stream_ctrl_pkg.sv
// piso_stream_ctrl_pkg: state encoding shared by the stream controller
package piso_stream_ctrl_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} st_e;
endpackage

// File: rtl/piso.sv
// piso: parallel-in serial-out shift register, MSB-first, load has priority over shift
module piso #(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [bits-1:0] d_in,
    output logic            s_out
);
    logic [bits-1:0] sr_q, sr_d;
    always_comb sr_d = load ? d_in : {sr_q[bits-2:0], 1'b0};
    always_ff @(posedge clk) sr_q <= rst ? '0 : sr_d;
    assign s_out = sr_q[bits-1];
endmodule

// File: rtl/piso_stream_ctrl.sv
// piso_stream_ctrl: buffers one word and reloads the piso on the last bit for gapless streaming
module piso_stream_ctrl
    import piso_stream_ctrl_pkg::*;
#(
    parameter int bits = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            piso_load,
    output logic [bits-1:0] piso_d,
    output logic            ser_valid,
    output logic            ser_first,
    output logic            ser_last,
    output logic            busy
);
    localparam int CW = $clog2(bits);
    localparam logic [CW-1:0] LAST = CW'(bits - 1);
    st_e             st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [bits-1:0] hold_data_q, hold_data_d;
    logic            hold_full_q, hold_full_d;
    always_comb begin
        in_ready    = !rst && !hold_full_q;
        // gated by rst so a word held at reset is never launched
        piso_load   = !rst && hold_full_q && (st_q == ST_IDLE || cnt_q == LAST);
        st_d        = st_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        if (in_valid && in_ready) begin
            hold_data_d = in_data;
            hold_full_d = 1'b1;
        end
        if (piso_load) begin
            st_d        = ST_SHIFT;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end else if (st_q == ST_SHIFT) begin
            st_d  = cnt_q == LAST ? ST_IDLE : ST_SHIFT;
            cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end
    assign piso_d    = hold_data_q;
    assign ser_valid = st_q == ST_SHIFT;
    assign ser_first = ser_valid && cnt_q == '0;
    assign ser_last  = ser_valid && cnt_q == LAST;
    assign busy      = ser_valid || hold_full_q;
endmodule

// File: tb/tb_piso_stream_ctrl.sv
// tb_piso_stream_ctrl: directed checks of the controller paired with a piso, bits=8 and bits=2
module tb_piso_stream_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready, piso_load, ser_valid, ser_first, ser_last, busy, s_out;
    logic [7:0] piso_d;
    logic [1:0] in_data2 = '0;
    logic       in_valid2 = 1'b0;
    logic       in_ready2, piso_load2, ser_valid2, ser_first2, ser_last2, busy2, s_out2;
    logic [1:0] piso_d2;
    int         pass_cnt = 0;
    int         total = 0;
    always #5 clk = ~clk;
    piso_stream_ctrl #(.bits(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .piso_load(piso_load), .piso_d(piso_d), .ser_valid(ser_valid), .ser_first(ser_first),
        .ser_last(ser_last), .busy(busy)
    );
    piso #(.bits(8)) u_piso (.clk(clk), .rst(rst), .load(piso_load), .d_in(piso_d), .s_out(s_out));
    piso_stream_ctrl #(.bits(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .piso_load(piso_load2), .piso_d(piso_d2), .ser_valid(ser_valid2), .ser_first(ser_first2),
        .ser_last(ser_last2), .busy(busy2)
    );
    piso #(.bits(2)) u_piso2 (.clk(clk), .rst(rst), .load(piso_load2), .d_in(piso_d2), .s_out(s_out2));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    initial begin
        logic [7:0] w [3];
        logic [1:0] w2 [3];
        logic [7:0] cur;
        int n;
        w[0] = 8'hCB; w[1] = 8'hA5; w[2] = 8'h3C;
        w2[0] = 2'b10; w2[1] = 2'b01; w2[2] = 2'b11;
        // reset held for two cycles
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 0);
        check("rst_load", 32'(piso_load), 0);
        check("rst_valid", 32'(ser_valid), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", 32'(in_ready), 1);
        // single word CB
        in_data = 8'hCB; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_load", 32'(piso_load), 1);
        check("t2_d", 32'(piso_d), 32'hCB);
        cur = 8'hCB;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t2_sout", 32'(s_out), 32'(cur[7-i]));
            check("t2_valid", 32'(ser_valid), 1);
            check("t2_first", 32'(ser_first), 32'(i == 0));
            check("t2_last", 32'(ser_last), 32'(i == 7));
        end
        @(negedge clk);
        check("t2_busy", 32'(busy), 0);
        check("t2_idle", 32'(ser_valid), 0);
        // stream CB, A5, 3C with in_valid held
        n = 0;
        for (int c = 0; c < 27; c++) begin
            if (c > 0) @(negedge clk);
            check("t3_load", 32'(piso_load), 32'(c == 1 || c == 9 || c == 17));
            check("t3_valid", 32'(ser_valid), 32'(c >= 2 && c <= 25));
            check("t3_last", 32'(ser_last), 32'(c == 9 || c == 17 || c == 25));
            if (c >= 2 && c <= 25) begin
                cur = w[(c-2)/8];
                check("t3_sout", 32'(s_out), 32'(cur[7-((c-2)%8)]));
            end
            in_valid = n < 3;
            if (n < 3) in_data = w[n];
            if (in_valid && in_ready) n++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        // backpressure: 5A held while FF is presented
        in_data = 8'h0F; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_data = 8'h5A;
        check("t4_acc", 32'(in_ready), 1);
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            in_data = 8'hFF;
            check("t4_ready", 32'(in_ready), 0);
            check("t4_hold", 32'(piso_d), 32'h5A);
        end
        in_valid = 1'b0;
        check("t4_load", 32'(piso_load), 1);
        cur = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_sout", 32'(s_out), 32'(cur[7-i]));
        end
        @(negedge clk);
        // reset mid-frame at cnt=3 of A5, with 3C held
        in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_data = 8'h3C; in_valid = 1'b1;
        cur = 8'hA5;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            check("t5_sout", 32'(s_out), 32'(cur[7-i]));
        end
        check("t5_held", 32'(busy && !in_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valid", 32'(ser_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_load", 32'(piso_load), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t5_ready", 32'(in_ready), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_noload", 32'(piso_load || ser_valid), 0);
        end
        // bits=2 stream 10, 01, 11
        n = 0;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            check("t6_load", 32'(piso_load2), 32'(c == 1 || c == 3 || c == 5));
            check("t6_valid", 32'(ser_valid2), 32'(c >= 2 && c <= 7));
            if (c >= 2 && c <= 7) begin
                check("t6_sout", 32'(s_out2), 32'((6'b100111 >> (7 - c)) & 1));
                check("t6_first", 32'(ser_first2), 32'(c % 2 == 0));
            end
            in_valid2 = n < 3;
            if (n < 3) in_data2 = w2[n];
            if (in_valid2 && in_ready2) n++;
        end
        in_valid2 = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
